// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Drains up to NUM_CH FWFT input FIFOs into one downstream FIFO
//               with round-robin / fixed-priority arbitration while the link is
//               active; registered output stage and 16-bit transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int                   WIDTH        = 10,
    parameter int                   NUM_CH       = 4,
    parameter int                   STATE_W      = 4,
    parameter logic [STATE_W-1:0]   ACTIVE_STATE = 4'b1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [STATE_W-1:0]      state,
    input  logic                    mode,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_empty,
    input  logic                    out_almost_full,
    output logic [NUM_CH-1:0]       in_pop,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_push,
    output logic [NUM_CH-1:0]       out_grant,
    output logic [15:0]             out_count
);

    localparam int               PTR_W  = $clog2(NUM_CH);
    localparam logic [PTR_W-1:0] c_last = PTR_W'(NUM_CH - 1);

    logic                   w_en;
    logic [NUM_CH-1:0]      w_req;
    logic                   w_found;
    logic [PTR_W-1:0]       w_idx;
    logic [PTR_W-1:0]       w_winner;
    logic                   w_pop_any;
    logic [WIDTH-1:0]       w_ch_data [NUM_CH];

    logic [PTR_W-1:0]       r_ptr;
    logic [WIDTH-1:0]       r_out_data;
    logic                   r_out_push;
    logic [NUM_CH-1:0]      r_out_grant;
    logic [15:0]            r_out_count;

    // Reset also gates the enable so no FIFO word is lost during the reset edge.
    assign w_en      = (state == ACTIVE_STATE) && !out_almost_full && !reset;
    assign w_req     = ~in_empty;
    assign w_pop_any = w_en && w_found;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
            assign w_ch_data[k] = in_data[k*WIDTH +: WIDTH];
            assign in_pop[k]    = w_pop_any && (w_winner == PTR_W'(k));
        end
    endgenerate

    // Search order starts at ptr in round-robin mode, at channel 0 otherwise.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mode) begin
                w_idx = PTR_W'(i);
            end else begin
                w_idx = PTR_W'((int'(r_ptr) + i) % NUM_CH);
            end
            if (!w_found && w_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_push  <= 1'b0;
            r_out_grant <= '0;
            r_out_count <= '0;
        end else begin
            r_out_push <= w_pop_any;
            if (w_pop_any) begin
                r_out_data  <= w_ch_data[w_winner];
                r_out_grant <= in_pop;
                r_out_count <= r_out_count + 16'd1;
                // Fixed-priority pops leave ptr alone so round-robin resumes where it left off.
                if (!mode) begin
                    r_ptr <= (w_winner == c_last) ? '0 : w_winner + PTR_W'(1);
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_push  = r_out_push;
    assign out_grant = r_out_grant;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Directed self-checking bench for mux_rr_arbiter (NUM_CH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    localparam int WIDTH   = 10;
    localparam int NUM_CH  = 4;
    localparam int STATE_W = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [STATE_W-1:0]      state;
    logic                    mode;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_empty;
    logic                    out_almost_full;
    logic [NUM_CH-1:0]       in_pop;
    logic [WIDTH-1:0]        out_data;
    logic                    out_push;
    logic [NUM_CH-1:0]       out_grant;
    logic [15:0]             out_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count;

    mux_rr_arbiter #(
        .WIDTH        (WIDTH),
        .NUM_CH       (NUM_CH),
        .STATE_W      (STATE_W),
        .ACTIVE_STATE (4'b1000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .state           (state),
        .mode            (mode),
        .in_data         (in_data),
        .in_empty        (in_empty),
        .out_almost_full (out_almost_full),
        .in_pop          (in_pop),
        .out_data        (out_data),
        .out_push        (out_push),
        .out_grant       (out_grant),
        .out_count       (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs changed afterwards belong to the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Registered outputs plus same-cycle pop, sampled 1ns into the cycle.
    task automatic check_out(input string tag, input logic push, input logic [3:0] grant,
                             input logic [9:0] data, input logic [15:0] cnt,
                             input logic [3:0] pop);
        #1;
        check({tag, ".push"},  32'(out_push),  32'(push));
        check({tag, ".grant"}, 32'(out_grant), 32'(grant));
        check({tag, ".data"},  32'(out_data),  32'(data));
        check({tag, ".count"}, 32'(out_count), 32'(cnt));
        check({tag, ".pop"},   32'(in_pop),    32'(pop));
    endtask

    initial begin
        reset           = 1'b1;
        state           = 4'b1000;
        mode            = 1'b0;
        in_data         = {10'h0A3, 10'h0A2, 10'h0A1, 10'h0A0};
        in_empty        = 4'b0000;
        out_almost_full = 1'b0;

        // Reset held two edges with every channel requesting
        tick(); check_out("rst1", 1'b0, 4'b0000, 10'h000, 16'd0, 4'b0000);
        tick(); check_out("rst2", 1'b0, 4'b0000, 10'h000, 16'd0, 4'b0000);

        // Round-robin rotation from channel 0
        reset = 1'b0;
        check_out("rr0", 1'b0, 4'b0000, 10'h000, 16'd0, 4'b0001);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_out("rr", 1'b1, 4'(1 << ((i - 1) % 4)), 10'(10'h0A0 + (i - 1) % 4),
                      16'(i), 4'(1 << (i % 4)));
        end

        // Fixed priority with channels 1 and 3; ptr is 1 after popping ch0
        tick();
        mode     = 1'b1;
        in_empty = 4'b0101;
        check_out("fp0", 1'b1, 4'b0001, 10'h0A0, 16'd5, 4'b0010);
        tick(); check_out("fp1", 1'b1, 4'b0010, 10'h0A1, 16'd6, 4'b0010);
        tick();
        in_empty = 4'b0111;
        check_out("fp2", 1'b1, 4'b0010, 10'h0A1, 16'd7, 4'b1000);
        tick();
        mode     = 1'b0;
        in_empty = 4'b0000;
        check_out("fp_back", 1'b1, 4'b1000, 10'h0A3, 16'd8, 4'b0010);

        // Gating by state: pops stop at once, last push still presents
        tick();
        state = 4'b0001;
        check_out("st0", 1'b1, 4'b0010, 10'h0A1, 16'd9, 4'b0000);
        tick();
        state = 4'b1000;
        check_out("st1", 1'b0, 4'b0010, 10'h0A1, 16'd9, 4'b0100);

        // Gating by almost-full
        tick();
        out_almost_full = 1'b1;
        check_out("af0", 1'b1, 4'b0100, 10'h0A2, 16'd10, 4'b0000);
        tick();
        out_almost_full = 1'b0;
        in_empty        = 4'b1011;
        check_out("af1", 1'b0, 4'b0100, 10'h0A2, 16'd10, 4'b0100);

        // Sparse: only ch2, ptr parks at 3, then all requesting proves ptr=3 and wrap
        tick(); check_out("sp0", 1'b1, 4'b0100, 10'h0A2, 16'd11, 4'b0100);
        tick();
        in_empty = 4'b0000;
        check_out("sp1", 1'b1, 4'b0100, 10'h0A2, 16'd12, 4'b1000);
        tick(); check_out("sp_wrap", 1'b1, 4'b1000, 10'h0A3, 16'd13, 4'b0001);

        // Counter wrap through continuous transfers
        exp_count = 13;
        while (exp_count < 16'hFFFE) begin
            tick();
            exp_count++;
        end
        #1 check("cnt_fffe", 32'(out_count), 32'h0000FFFE);
        tick(); #1 check("cnt_ffff", 32'(out_count), 32'h0000FFFF);
        tick(); #1 check("cnt_wrap", 32'(out_count), 32'h00000000);
        check("cnt_wrap_push", 32'(out_push), 32'd1);

        // Reset in the cycle after a pop of ch0 (ptr=1), ch0 and ch2 requesting
        in_empty = 4'b1110;
        #1 check("mr_pop", 32'(in_pop), 32'b0001);
        tick();
        reset    = 1'b1;
        in_empty = 4'b1010;
        #1;
        check("mr_pop_gated", 32'(in_pop), 32'd0);
        check("mr_push_pre", 32'(out_push), 32'd1);
        check("mr_data_pre", 32'(out_data), 32'h0A0);
        tick();
        reset = 1'b0;
        check_out("mr_post", 1'b0, 4'b0000, 10'h000, 16'd0, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
